// File: rtl/if_stage.sv
// Instruction-fetch stage: drives a single-outstanding-request imem bus and owns the IF/ID register.
// Optional IF_ADDR_EXC_EN adds an id_adel output for misaligned fetch addresses.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_instr
`ifdef IF_ADDR_EXC_EN
    ,
    output logic        id_adel
`endif
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] drop_addr_reg, drop_addr_next;
    logic [31:0] buffer_reg, buffer_next;
    logic        id_valid_reg;
    logic [31:0] id_pc_reg, id_pc4_reg, id_instr_reg;

    logic        load_en;
    logic        bubble;
    logic [31:0] load_instr;
    logic        misaligned;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_reg + 32'd4;

`ifdef IF_ADDR_EXC_EN
    assign misaligned = (pc_reg[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Reset gates the request combinationally so an in-flight fetch is dropped at once.
    assign imem_req  = !rst && ((state_reg == DROP) || (state_reg == FETCH && !misaligned));
    assign imem_addr = (state_reg == DROP) ? drop_addr_reg : pc_reg;

    assign pc       = pc_reg;
    assign id_valid = id_valid_reg;
    assign id_pc    = id_pc_reg;
    assign id_pc4   = id_pc4_reg;
    assign id_instr = id_instr_reg;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        drop_addr_next = drop_addr_reg;
        buffer_next    = buffer_reg;
        load_en        = 1'b0;
        bubble         = 1'b0;
        load_instr     = 32'h0;
        case (state_reg)
            FETCH: begin
                if (flush) begin
                    pc_next     = flush_pc;
                    bubble      = 1'b1;
                    buffer_next = 32'h0;
                    // Without an ack the old request is still on the bus and must be drained.
                    if (!imem_ack && !misaligned) begin
                        drop_addr_next = pc_reg;
                        state_next     = DROP;
                    end
                end else if (misaligned) begin
                    if (!stall) begin
                        load_en = 1'b1;
                        pc_next = npc;
                    end
                end else if (imem_ack) begin
                    if (!stall) begin
                        load_en    = 1'b1;
                        load_instr = imem_rdata;
                        pc_next    = npc;
                    end else begin
                        buffer_next = imem_rdata;
                        state_next  = HOLD;
                    end
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_next     = flush_pc;
                    bubble      = 1'b1;
                    buffer_next = 32'h0;
                    state_next  = FETCH;
                end else if (!stall) begin
                    load_en    = 1'b1;
                    load_instr = buffer_reg;
                    pc_next    = npc;
                    state_next = FETCH;
                end
            end
            DROP: begin
                if (flush) begin
                    pc_next = flush_pc;
                    bubble  = 1'b1;
                end
                if (imem_ack) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= FETCH;
            pc_reg        <= RESET_PC;
            drop_addr_reg <= 32'h0;
            buffer_reg    <= 32'h0;
            id_valid_reg  <= 1'b0;
            id_pc_reg     <= RESET_PC;
            id_pc4_reg    <= RESET_PC + 32'd4;
            id_instr_reg  <= 32'h0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            drop_addr_reg <= drop_addr_next;
            buffer_reg    <= buffer_next;
            if (load_en) begin
                id_valid_reg <= 1'b1;
                id_pc_reg    <= pc_reg;
                id_pc4_reg   <= pc_plus4;
                id_instr_reg <= load_instr;
            end else if (bubble) begin
                id_valid_reg <= 1'b0;
            end
        end
    end

`ifdef IF_ADDR_EXC_EN
    logic id_adel_reg;
    assign id_adel = id_adel_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_adel_reg <= 1'b0;
        end else if (load_en) begin
            id_adel_reg <= misaligned;
        end else if (bubble) begin
            id_adel_reg <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a cycle table for the main flows plus short hand-written
// sequences for pc+4 wrap, the IF_ADDR_EXC_EN exception and reset during a request.
module tb_if_stage;

    localparam logic [31:0] RDATA_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc, pc, flush_pc, imem_addr, imem_rdata;
    logic [31:0] id_pc, id_pc4, id_instr;
    logic        stall, flush, imem_req, imem_ack, id_valid;
`ifdef IF_ADDR_EXC_EN
    logic        id_adel;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Zero-wait memory: data word is the address scrambled by a fixed key.
    assign imem_rdata = imem_addr ^ RDATA_KEY;
    assign npc        = pc + 32'd4;

    if_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .npc(npc), .pc(pc),
        .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr)
`ifdef IF_ADDR_EXC_EN
        , .id_adel(id_adel)
`endif
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic        ack;
        logic [31:0] fpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] idpc;
        logic [31:0] pcv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic f, input logic a, input logic [31:0] fp,
                       input logic r, input logic [31:0] ad, input logic v,
                       input logic [31:0] ip, input logic [31:0] p);
        vec_t t;
        t.stall = s; t.flush = f; t.ack = a; t.fpc = fp;
        t.req = r; t.addr = ad; t.valid = v; t.idpc = ip; t.pcv = p;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        // stall flush ack flush_pc | req addr valid id_pc pc  (state seen before the edge)
        add(0,0,1,32'h0,    1,32'h3000,0,32'h3000,32'h3000);
        add(0,0,1,32'h0,    1,32'h3004,1,32'h3000,32'h3004);
        add(1,0,1,32'h0,    1,32'h3008,1,32'h3004,32'h3008);
        add(1,0,0,32'h0,    0,32'h0,   1,32'h3004,32'h3008);
        add(1,0,0,32'h0,    0,32'h0,   1,32'h3004,32'h3008);
        add(0,0,0,32'h0,    0,32'h0,   1,32'h3004,32'h3008);
        add(0,0,0,32'h0,    1,32'h300C,1,32'h3008,32'h300C);
        add(0,0,1,32'h0,    1,32'h300C,0,32'h3008,32'h300C);
        add(0,0,0,32'h0,    1,32'h3010,1,32'h300C,32'h3010);
        add(0,1,0,32'h3400, 1,32'h3010,0,32'h300C,32'h3010);
        add(0,0,0,32'h0,    1,32'h3010,0,32'h300C,32'h3400);
        add(0,0,1,32'h0,    1,32'h3010,0,32'h300C,32'h3400);
        add(0,0,1,32'h0,    1,32'h3400,0,32'h300C,32'h3400);
        add(1,1,1,32'h3800, 1,32'h3404,1,32'h3400,32'h3404);
        add(0,0,0,32'h0,    1,32'h3800,0,32'h3400,32'h3800);
        add(0,0,1,32'h0,    1,32'h3800,0,32'h3400,32'h3800);
        add(1,0,0,32'h0,    1,32'h3804,1,32'h3800,32'h3804);
        add(1,0,1,32'h0,    1,32'h3804,1,32'h3800,32'h3804);
        add(1,1,0,32'h3900, 0,32'h0,   1,32'h3800,32'h3804);
        add(0,0,0,32'h0,    1,32'h3900,0,32'h3800,32'h3900);
        add(0,1,0,32'h3A00, 1,32'h3900,0,32'h3800,32'h3900);
        add(0,1,0,32'h3B00, 1,32'h3900,0,32'h3800,32'h3A00);
        add(0,0,1,32'h0,    1,32'h3900,0,32'h3800,32'h3B00);
        add(0,0,1,32'h0,    1,32'h3B00,0,32'h3800,32'h3B00);
        add(0,0,0,32'h0,    1,32'h3B04,1,32'h3B00,32'h3B04);

        rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = 32'h0; imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_req", {31'h0, imem_req}, 32'h0);
        chk("reset_pc", pc, 32'h3000);
        chk("reset_valid", {31'h0, id_valid}, 32'h0);
        chk("reset_id_pc", id_pc, 32'h3000);
        chk("reset_id_pc4", id_pc4, 32'h3004);
        chk("reset_id_instr", id_instr, 32'h0);
`ifdef IF_ADDR_EXC_EN
        chk("reset_adel", {31'h0, id_adel}, 32'h0);
`endif
        $display("reset: req=%b pc=%h id_valid=%b", imem_req, pc, id_valid);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = 1'b0;
            stall = vecs[i].stall; flush = vecs[i].flush;
            imem_ack = vecs[i].ack; flush_pc = vecs[i].fpc;
            #1;
            $display("vec %0d: req=%b addr=%h ack=%b stall=%b flush=%b id_valid=%b id_pc=%h pc=%h",
                     i, imem_req, imem_addr, imem_ack, stall, flush, id_valid, id_pc, pc);
            chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].req});
            if (vecs[i].req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_valid", i), {31'h0, id_valid}, {31'h0, vecs[i].valid});
            chk($sformatf("v%0d_id_pc", i), id_pc, vecs[i].idpc);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].pcv);
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_instr", i), id_instr, vecs[i].idpc ^ RDATA_KEY);
                chk($sformatf("v%0d_pc4", i), id_pc4, vecs[i].idpc + 32'd4);
            end
`ifdef IF_ADDR_EXC_EN
            chk($sformatf("v%0d_adel", i), {31'h0, id_adel}, 32'h0);
`endif
        end

        // pc+4 wrap at the top of the address space
        @(negedge clk);
        stall = 1'b0; flush = 1'b1; flush_pc = 32'hFFFF_FFFC; imem_ack = 1'b1;
        @(negedge clk);
        flush = 1'b0; imem_ack = 1'b1;
        #1;
        $display("wrap: req=%b addr=%h", imem_req, imem_addr);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        flush = 1'b1; flush_pc = 32'h0000_3002; imem_ack = 1'b1;
        #1;
        $display("wrap: id_valid=%b id_pc=%h id_pc4=%h pc=%h", id_valid, id_pc, id_pc4, pc);
        chk("wrap_valid", {31'h0, id_valid}, 32'h1);
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_id_pc4", id_pc4, 32'h0);
        chk("wrap_pc", pc, 32'h0);

        // Misaligned fetch at 3002
        @(negedge clk);
        flush = 1'b0; imem_ack = 1'b0;
        #1;
        $display("misaligned: req=%b addr=%h pc=%h", imem_req, imem_addr, pc);
        chk("mis_pc", pc, 32'h3002);
`ifdef IF_ADDR_EXC_EN
        chk("mis_no_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        #1;
        $display("misaligned: id_valid=%b id_pc=%h id_instr=%h id_adel=%b", id_valid, id_pc, id_instr, id_adel);
        chk("mis_valid", {31'h0, id_valid}, 32'h1);
        chk("mis_id_pc", id_pc, 32'h3002);
        chk("mis_instr", id_instr, 32'h0);
        chk("mis_adel", {31'h0, id_adel}, 32'h1);
`else
        chk("mis_req", {31'h0, imem_req}, 32'h1);
        chk("mis_addr", imem_addr, 32'h3002);
`endif

        // Reset with a request pending; ack during reset must be ignored
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b1;
        #1;
        $display("mid-reset: req=%b pc=%h id_valid=%b", imem_req, pc, id_valid);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_pc", pc, 32'h3000);
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0;
        #1;
        $display("post-reset: req=%b addr=%h id_valid=%b", imem_req, imem_addr, id_valid);
        chk("post_req", {31'h0, imem_req}, 32'h1);
        chk("post_addr", imem_addr, 32'h3000);
        chk("post_valid", {31'h0, id_valid}, 32'h0);
        @(negedge clk);
        imem_ack = 1'b1;
        #1;
        chk("late_valid", {31'h0, id_valid}, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        $display("post-reset fetch: id_valid=%b id_pc=%h id_instr=%h", id_valid, id_pc, id_instr);
        chk("first_valid", {31'h0, id_valid}, 32'h1);
        chk("first_id_pc", id_pc, 32'h3000);
        chk("first_instr", id_instr, 32'h3000 ^ RDATA_KEY);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_3000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: npc  input  32  next PC from the next-PC stage.
REQ-005 SHALL have port: pc  output  32  current fetch PC, fed back to the next-PC stage.
REQ-006 SHALL have port: stall  input  1  decode cannot accept; hold IF/ID and PC.
REQ-007 SHALL have port: flush  input  1  redirect request; discard fetched and in-flight instructions.
REQ-008 SHALL have port: flush_pc  input  32  redirect target, sampled when flush=1.
REQ-009 SHALL have ports: imem_req out 1; imem_addr out 32; imem_ack in 1; imem_rdata in 32 (instruction memory handshake).
REQ-010 SHALL have ports: id_valid out 1; id_pc out 32; id_pc4 out 32; id_instr out 32 (IF/ID register).

Function
REQ-011 SHALL implement states FETCH, HOLD, DROP.
REQ-012 Bus rule: imem_req=1 in FETCH and DROP, 0 in HOLD. imem_addr SHALL stay constant while imem_req=1 and imem_ack=0.
REQ-013 imem_addr SHALL equal pc in FETCH and the abandoned request address in DROP.
REQ-014 FETCH, ack=1, stall=0, flush=0: IF/ID <= {1, pc, pc+4, imem_rdata}; pc <= npc; stay FETCH.
REQ-015 FETCH, ack=1, stall=1, flush=0: rdata captured into holding buffer; pc and IF/ID unchanged; go HOLD.
REQ-016 FETCH, ack=0, flush=0: if stall=0, id_valid <= 0 (bubble); if stall=1, IF/ID held; pc unchanged.
REQ-017 HOLD, stall=0, flush=0: IF/ID <= {1, pc, pc+4, buffer}; pc <= npc; go FETCH.
REQ-018 HOLD, stall=1, flush=0: everything held.
REQ-019 flush=1 in any state SHALL take priority over stall and ack: pc <= flush_pc; id_valid <= 0; buffer discarded.
REQ-020 flush=1 in FETCH with ack=0: latch the old address; go DROP. With ack=1: discard rdata; stay FETCH.
REQ-021 DROP: on ack, discard rdata and go FETCH, which issues flush_pc the next cycle. A further flush in DROP updates pc only.
REQ-022 pc+4 SHALL be modulo 2^32, so 32'hFFFF_FFFC gives 32'h0000_0000.
REQ-023 Latency: ack in cycle N gives id_valid=1 in cycle N+1 (no stall). One request is outstanding at most.

Reset
REQ-024 rst=1 SHALL immediately force: state FETCH; pc=RESET_PC; id_valid=0; id_pc=RESET_PC; id_pc4=RESET_PC+4; id_instr=0; buffer cleared.
REQ-025 imem_req SHALL be 0 while rst=1. The first request SHALL go out in the first cycle after rst deasserts.
REQ-026 Reset mid-request SHALL abandon it with no DROP. Acks arriving during reset SHALL be ignored.

Configuration
REQ-027 Macro IF_ADDR_EXC_EN, when defined, SHALL add output id_adel (1 bit, reset 0).
REQ-028 With IF_ADDR_EXC_EN: in FETCH with pc[1:0]!=0, no request is issued. When stall=0, IF/ID <= {1, pc, pc+4, 32'h0} with id_adel=1, and pc <= npc. id_adel=0 on every normal load.
REQ-029 Without IF_ADDR_EXC_EN: no id_adel port, and pc[1:0] passes to imem_addr unchecked.

Verification
REQ-030 Reset release, 1-cycle ack memory, npc=pc+4 -> imem_addr 3000, 3004, 3008; id_pc follows one cycle later, id_valid=1 from cycle 2.
REQ-031 Ack at pc=3008 with stall=1 for 3 cycles -> HOLD, imem_req=0, IF/ID frozen at 3004. Stall drop -> id_pc=3008, id_instr=buffered word, then request 300C.
REQ-032 Request 3010 pending, flush=1 with flush_pc=3400 -> imem_addr stays 3010 until ack, rdata discarded, id_valid=0. Next request is 3400.
REQ-033 Flush and ack in the same cycle with stall=1 -> rdata dropped, pc=flush_pc, id_valid=0, next request is flush_pc.
REQ-034 rst asserted with a request pending -> imem_req=0 and pc=3000 in the same cycle. After release, the first request is 3000 and a late ack does not load IF/ID.
REQ-035 With IF_ADDR_EXC_EN and npc=3002 -> no request for 3002, id_adel=1, id_instr=0, id_pc=3002.
